// File: rtl/io_pkg.sv
// Shared defaults for the multi-channel programmed-I/O controller and the
// interrupt source-index type sized for the default channel count.
package io_pkg;

  localparam int IO_DATA_WIDTH = 8;
  localparam int IO_NCH        = 4;
  localparam int IO_FIFO_DEPTH = 4;
  localparam int IO_SRC_W      = $clog2(2 * IO_NCH);

  typedef logic [IO_SRC_W-1:0] io_src_t;

endpackage

// File: rtl/io_fifo.sv
// Synchronous single-clock FIFO; push on full and pop on empty are ignored,
// and the head reads as zero while empty.
module io_fifo
  import io_pkg::*;
#(
  parameter int DATA_WIDTH = IO_DATA_WIDTH,
  parameter int DEPTH      = IO_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // next-state for storage, pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_q == count_q ? count_d : count_d;
    end
  end

endmodule

// File: rtl/io_channel_ctrl.sv
// Multi-channel programmed-I/O controller with per-channel FIFOs, masks and a
// vectored interrupt. Define IO_RR_PRIO_EN for round-robin interrupt priority.
module io_channel_ctrl
  import io_pkg::*;
#(
  parameter int DATA_WIDTH = IO_DATA_WIDTH,
  parameter int NCH        = IO_NCH,
  parameter int FIFO_DEPTH = IO_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            dev_in_valid,
  input  logic [NCH*DATA_WIDTH-1:0] dev_in_data,
  output logic [NCH-1:0]            dev_in_ready,
  output logic [NCH-1:0]            dev_out_valid,
  output logic [NCH*DATA_WIDTH-1:0] dev_out_data,
  input  logic [NCH-1:0]            dev_out_ready,
  input  logic [$clog2(NCH)-1:0]    sel,
  input  logic                      cpu_inp,
  output logic [DATA_WIDTH-1:0]     cpu_rdata,
  input  logic                      cpu_out,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata,
  output logic [NCH-1:0]            fgi,
  output logic [NCH-1:0]            fgo,
  input  logic                      mask_we,
  input  logic [2*NCH-1:0]          mask_wdata,
  input  logic                      ien_set,
  input  logic                      ien_clr,
  input  logic                      irq_ack,
  output logic                      ien,
  output logic                      irq,
  output logic [$clog2(2*NCH)-1:0]  irq_vec,
  output logic [NCH-1:0]            ovf
);

  localparam int SELW = $clog2(NCH);
  localparam int NSRC = 2 * NCH;
  localparam int SW   = $clog2(NSRC);

  logic [NCH-1:0]        in_full, in_empty, out_full, out_empty;
  logic [NCH-1:0]        inp_hit, out_hit;
  logic [DATA_WIDTH-1:0] in_head [NCH];
  logic [NSRC-1:0]       pend;
  logic [SW-1:0]         prio_start;
  logic [NSRC-1:0]       mask_q, mask_d;
  logic                  ien_q, ien_d;
  logic                  irq_q, irq_d;
  logic [SW-1:0]         irq_vec_q, irq_vec_d;
  logic [NCH-1:0]        ovf_q, ovf_d;
`ifdef IO_RR_PRIO_EN
  logic [SW-1:0]         ptr_q, ptr_d;
`endif

  // Search req starting at index start, wrapping past NSRC-1 back to 0.
  function automatic logic [SW-1:0] arbitrate(input logic [NSRC-1:0] req,
                                              input logic [SW-1:0]   start);
    logic [SW-1:0] win;
    logic          found;
    int            idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      idx = (int'(start) + k) % NSRC;
      if (!found && req[idx]) begin
        win   = SW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // decode the CPU strobes onto the addressed channel and mux its input head
  always_comb begin
    cpu_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      inp_hit[i] = cpu_inp && (sel == SELW'(i));
      out_hit[i] = cpu_out && (sel == SELW'(i));
      if (sel == SELW'(i)) begin
        cpu_rdata = in_head[i];
      end else begin
        cpu_rdata = cpu_rdata;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    io_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (dev_in_valid[i]),
      .wdata (dev_in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop   (inp_hit[i]),
      .head  (in_head[i]),
      .full  (in_full[i]),
      .empty (in_empty[i])
    );
    io_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (out_hit[i]),
      .wdata (cpu_wdata),
      .pop   (dev_out_ready[i]),
      .head  (dev_out_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .full  (out_full[i]),
      .empty (out_empty[i])
    );
  end

  assign dev_in_ready  = ~in_full;
  assign fgi           = ~in_empty;
  assign fgo           = ~out_full;
  assign dev_out_valid = ~out_empty;

  // interrupt, mask and overflow next-state
  always_comb begin
    pend      = {fgo & mask_q[NSRC-1:NCH], fgi & mask_q[NCH-1:0]};
`ifdef IO_RR_PRIO_EN
    prio_start = ptr_q;
    if (irq_ack) begin
      ptr_d = (irq_vec_q == SW'(NSRC - 1)) ? '0 : irq_vec_q + SW'(1);
    end else begin
      ptr_d = ptr_q;
    end
`else
    prio_start = '0;
`endif
    mask_d    = mask_we ? mask_wdata : mask_q;
    if (ien_clr || irq_ack) begin
      ien_d = 1'b0;
    end else if (ien_set) begin
      ien_d = 1'b1;
    end else begin
      ien_d = ien_q;
    end
    irq_d     = ien_q & (|pend) & ~irq_ack;
    irq_vec_d = irq_d ? arbitrate(pend, prio_start) : irq_vec_q;
    // a push into a full output FIFO is lost even if the device pops this cycle
    ovf_d     = ovf_q | (out_hit & out_full);
  end

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q    <= '0;
      ien_q     <= 1'b0;
      irq_q     <= 1'b0;
      irq_vec_q <= '0;
      ovf_q     <= '0;
`ifdef IO_RR_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      mask_q    <= mask_d;
      ien_q     <= ien_d;
      irq_q     <= irq_d;
      irq_vec_q <= irq_vec_d;
      ovf_q     <= ovf_d;
`ifdef IO_RR_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign ien     = ien_q;
  assign irq     = irq_q;
  assign irq_vec = irq_vec_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_io_channel_ctrl.sv
// Self-checking bench for io_channel_ctrl: directed table, corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_io_channel_ctrl;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int SELW = $clog2(N);
  localparam int VW = $clog2(2 * N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      dev_in_valid;
  logic [N*DW-1:0]   dev_in_data;
  logic [N-1:0]      dev_in_ready;
  logic [N-1:0]      dev_out_valid;
  logic [N*DW-1:0]   dev_out_data;
  logic [N-1:0]      dev_out_ready;
  logic [SELW-1:0]   sel;
  logic              cpu_inp;
  logic [DW-1:0]     cpu_rdata;
  logic              cpu_out;
  logic [DW-1:0]     cpu_wdata;
  logic [N-1:0]      fgi, fgo;
  logic              mask_we;
  logic [2*N-1:0]    mask_wdata;
  logic              ien_set, ien_clr, irq_ack;
  logic              ien, irq;
  logic [VW-1:0]     irq_vec;
  logic [N-1:0]      ovf;

  io_channel_ctrl #(.DATA_WIDTH(DW), .NCH(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .dev_in_valid(dev_in_valid), .dev_in_data(dev_in_data), .dev_in_ready(dev_in_ready),
    .dev_out_valid(dev_out_valid), .dev_out_data(dev_out_data), .dev_out_ready(dev_out_ready),
    .sel(sel), .cpu_inp(cpu_inp), .cpu_rdata(cpu_rdata), .cpu_out(cpu_out), .cpu_wdata(cpu_wdata),
    .fgi(fgi), .fgo(fgo), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .ien_set(ien_set), .ien_clr(ien_clr), .irq_ack(irq_ack),
    .ien(ien), .irq(irq), .irq_vec(irq_vec), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; dev_in_valid = '0; dev_in_data = '0; dev_out_ready = '0;
    sel = '0; cpu_inp = 1'b0; cpu_out = 1'b0; cpu_wdata = '0;
    mask_we = 1'b0; mask_wdata = '0; ien_set = 1'b0; ien_clr = 1'b0; irq_ack = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]    div;
    logic [N*DW-1:0] din;
    logic [SELW-1:0] sel;
    logic            inp;
    logic            out;
    logic [DW-1:0]   wd;
    logic [N-1:0]    e_fgi;
    logic [N-1:0]    e_fgo;
    logic [N-1:0]    e_dov;
    logic [N-1:0]    e_ovf;
    logic [DW-1:0]   e_rdata;
    logic [N*DW-1:0] e_dout;
  } vec_t;

  vec_t tbl [10];

  // reference model: plain queues per channel plus interrupt bookkeeping
  logic [DW-1:0] in_q  [N][$];
  logic [DW-1:0] out_q [N][$];
  logic [N-1:0]   ovf_m;
  logic [2*N-1:0] mask_m;
  logic           ien_m, irq_m;
  int             vec_m, ptr_m;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      in_q[i].delete();
      out_q[i].delete();
    end
    ovf_m = '0; mask_m = '0; ien_m = 1'b0; irq_m = 1'b0; vec_m = 0; ptr_m = 0;
  endtask

  task automatic model_step();
    logic [2*N-1:0] pend;
    logic           new_irq;
    int             new_vec, in_pre, out_pre, idx;
    logic           found;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      pend[i]     = (in_q[i].size() > 0) && mask_m[i];
      pend[N + i] = (out_q[i].size() < D) && mask_m[N + i];
    end
    new_irq = ien_m && (pend != '0) && !irq_ack;
    new_vec = vec_m;
    found   = 1'b0;
    if (new_irq) begin
      for (int k = 0; k < 2 * N; k++) begin
        idx = (ptr_m + k) % (2 * N);
        if (!found && pend[idx]) begin
          new_vec = idx;
          found   = 1'b1;
        end
      end
    end
`ifdef IO_RR_PRIO_EN
    if (irq_ack) ptr_m = (vec_m + 1) % (2 * N);
`endif
    irq_m = new_irq;
    vec_m = new_vec;
    if (ien_clr || irq_ack) ien_m = 1'b0;
    else if (ien_set) ien_m = 1'b1;
    if (mask_we) mask_m = mask_wdata;
    for (int i = 0; i < N; i++) begin
      in_pre  = in_q[i].size();
      out_pre = out_q[i].size();
      if (cpu_inp && sel == SELW'(i) && in_pre > 0) void'(in_q[i].pop_front());
      if (dev_in_valid[i] && in_pre < D) in_q[i].push_back(dev_in_data[i*DW +: DW]);
      if (dev_out_ready[i] && out_pre > 0) void'(out_q[i].pop_front());
      if (cpu_out && sel == SELW'(i)) begin
        if (out_pre < D) out_q[i].push_back(cpu_wdata);
        else ovf_m[i] = 1'b1;
      end
    end
  endtask

  task automatic model_compare();
    logic [N-1:0]    e_fgi, e_fgo, e_rdy, e_dov;
    logic [N*DW-1:0] e_dout;
    logic [DW-1:0]   e_rd;
    e_dout = '0;
    for (int i = 0; i < N; i++) begin
      e_fgi[i] = in_q[i].size() > 0;
      e_rdy[i] = in_q[i].size() < D;
      e_dov[i] = out_q[i].size() > 0;
      e_fgo[i] = out_q[i].size() < D;
      if (out_q[i].size() > 0) e_dout[i*DW +: DW] = out_q[i][0];
    end
    e_rd = (in_q[sel].size() > 0) ? in_q[sel][0] : '0;
    chk("rnd_fgi", 64'(fgi), 64'(e_fgi));
    chk("rnd_fgo", 64'(fgo), 64'(e_fgo));
    chk("rnd_in_ready", 64'(dev_in_ready), 64'(e_rdy));
    chk("rnd_out_valid", 64'(dev_out_valid), 64'(e_dov));
    chk("rnd_out_data", 64'(dev_out_data), 64'(e_dout));
    chk("rnd_rdata", 64'(cpu_rdata), 64'(e_rd));
    chk("rnd_ien", 64'(ien), 64'(ien_m));
    chk("rnd_irq", 64'(irq), 64'(irq_m));
    chk("rnd_irq_vec", 64'(irq_vec), 64'(vec_m));
    chk("rnd_ovf", 64'(ovf), 64'(ovf_m));
  endtask

  initial begin
    logic [VW-1:0] exp_second;
    tbl[0] = '{4'b0100, 32'h0041_0000, 2'd2, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 8'h41, 32'h0};
    tbl[1] = '{4'b0100, 32'h0042_0000, 2'd2, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 8'h41, 32'h0};
    tbl[2] = '{4'b0000, 32'h0,         2'd2, 1'b1, 1'b0, 8'h00, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 8'h42, 32'h0};
    tbl[3] = '{4'b0000, 32'h0,         2'd2, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 32'h0};
    tbl[4] = '{4'b0000, 32'h0,         2'd2, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 32'h0};
    tbl[5] = '{4'b0000, 32'h0,         2'd1, 1'b0, 1'b1, 8'h10, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 8'h00, 32'h0000_1000};
    tbl[6] = '{4'b0000, 32'h0,         2'd1, 1'b0, 1'b1, 8'h11, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 8'h00, 32'h0000_1000};
    tbl[7] = '{4'b0000, 32'h0,         2'd1, 1'b0, 1'b1, 8'h12, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 8'h00, 32'h0000_1000};
    tbl[8] = '{4'b0000, 32'h0,         2'd1, 1'b0, 1'b1, 8'h13, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 8'h00, 32'h0000_1000};
    tbl[9] = '{4'b0000, 32'h0,         2'd1, 1'b0, 1'b1, 8'h14, 4'b0000, 4'b1101, 4'b0010, 4'b0010, 8'h00, 32'h0000_1000};

    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_fgi", 64'(fgi), 64'(4'b0000));
    chk("rst_fgo", 64'(fgo), 64'(4'b1111));
    chk("rst_in_ready", 64'(dev_in_ready), 64'(4'b1111));
    chk("rst_out_valid", 64'(dev_out_valid), 64'(4'b0000));
    chk("rst_out_data", 64'(dev_out_data), 64'(32'h0));
    chk("rst_irq", 64'(irq), 64'(1'b0));
    chk("rst_irq_vec", 64'(irq_vec), 64'(3'd0));
    chk("rst_ovf", 64'(ovf), 64'(4'b0000));
    chk("rst_ien", 64'(ien), 64'(1'b0));

    // input read-back on channel 2 and output overflow on channel 1
    for (int r = 0; r < 10; r++) begin
      dev_in_valid = tbl[r].div; dev_in_data = tbl[r].din; sel = tbl[r].sel;
      cpu_inp = tbl[r].inp; cpu_out = tbl[r].out; cpu_wdata = tbl[r].wd;
      tick();
      chk($sformatf("tbl%0d_fgi", r), 64'(fgi), 64'(tbl[r].e_fgi));
      chk($sformatf("tbl%0d_fgo", r), 64'(fgo), 64'(tbl[r].e_fgo));
      chk($sformatf("tbl%0d_dov", r), 64'(dev_out_valid), 64'(tbl[r].e_dov));
      chk($sformatf("tbl%0d_ovf", r), 64'(ovf), 64'(tbl[r].e_ovf));
      chk($sformatf("tbl%0d_rdata", r), 64'(cpu_rdata), 64'(tbl[r].e_rdata));
      chk($sformatf("tbl%0d_dout", r), 64'(dev_out_data), 64'(tbl[r].e_dout));
    end
    idle();

    // device drains exactly the four accepted characters
    dev_out_ready = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_valid", k), 64'(dev_out_valid[1]), 64'(1'b1));
      chk($sformatf("drain%0d_data", k), 64'(dev_out_data[15:8]), 64'(8'h10 + 8'(k)));
      tick();
    end
    dev_out_ready = '0;
    chk("drain_empty", 64'(dev_out_valid), 64'(4'b0000));
    chk("drain_fgo", 64'(fgo), 64'(4'b1111));
    chk("drain_ovf_sticky", 64'(ovf), 64'(4'b0010));

    // interrupt: fill all output FIFOs, enable, then make inputs 0 and 3 pending
    for (int c = 0; c < N; c++) begin
      for (int k = 0; k < D; k++) begin
        sel = SELW'(c); cpu_out = 1'b1; cpu_wdata = 8'($urandom);
        tick();
      end
    end
    cpu_out = 1'b0;
    chk("irq_fgo_full", 64'(fgo), 64'(4'b0000));
    mask_we = 1'b1; mask_wdata = 8'hFF; ien_set = 1'b1;
    tick();
    mask_we = 1'b0; ien_set = 1'b0;
    chk("irq_ien_set", 64'(ien), 64'(1'b1));
    chk("irq_idle", 64'(irq), 64'(1'b0));
    dev_in_valid = 4'b1001; dev_in_data = 32'($urandom);
    tick();
    dev_in_valid = '0;
    chk("irq_flags", 64'(fgi), 64'(4'b1001));
    chk("irq_not_yet", 64'(irq), 64'(1'b0));
    tick();
    chk("irq_rise", 64'(irq), 64'(1'b1));
    chk("irq_vec0", 64'(irq_vec), 64'(3'd0));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("ack_irq", 64'(irq), 64'(1'b0));
    chk("ack_ien", 64'(ien), 64'(1'b0));
    chk("ack_vec_hold", 64'(irq_vec), 64'(3'd0));
    tick();
    chk("ack_stays_low", 64'(irq), 64'(1'b0));

`ifdef IO_RR_PRIO_EN
    exp_second = 3'd3;
`else
    exp_second = 3'd0;
`endif
    ien_set = 1'b1; tick(); ien_set = 1'b0;
    tick();
    chk("grant2_irq", 64'(irq), 64'(1'b1));
    chk("grant2_vec", 64'(irq_vec), 64'(exp_second));
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    ien_set = 1'b1; tick(); ien_set = 1'b0;
    tick();
    chk("grant3_irq", 64'(irq), 64'(1'b1));
    chk("grant3_vec", 64'(irq_vec), 64'(3'd0));
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;

    // reset while output FIFO 0 holds three entries
    dev_out_ready = 4'b0001; tick(); dev_out_ready = '0;
    chk("pre_rst_dov", 64'(dev_out_valid), 64'(4'b1111));
    chk("pre_rst_fgo", 64'(fgo), 64'(4'b0001));
    chk("pre_rst_ovf", 64'(ovf), 64'(4'b0010));
    rst = 1'b1; dev_in_valid = 4'b1111; cpu_out = 1'b1; sel = '0;
    tick();
    idle();
    chk("mid_rst_dov", 64'(dev_out_valid), 64'(4'b0000));
    chk("mid_rst_fgo", 64'(fgo), 64'(4'b1111));
    chk("mid_rst_ovf", 64'(ovf), 64'(4'b0000));
    chk("mid_rst_fgi", 64'(fgi), 64'(4'b0000));
    chk("mid_rst_ien", 64'(ien), 64'(1'b0));

    // randomized traffic against the reference model
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst           = ($urandom_range(0, 399) == 0);
      dev_in_valid  = N'($urandom);
      dev_in_data   = 32'($urandom);
      dev_out_ready = N'($urandom) & N'($urandom);
      sel           = SELW'($urandom);
      cpu_inp       = ($urandom_range(0, 2) == 0);
      cpu_out       = ($urandom_range(0, 1) == 0);
      cpu_wdata     = DW'($urandom);
      mask_we       = ($urandom_range(0, 31) == 0);
      mask_wdata    = (2*N)'($urandom);
      ien_set       = ($urandom_range(0, 7) == 0);
      ien_clr       = ($urandom_range(0, 31) == 0);
      irq_ack       = irq_m ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
      model_step();
      tick();
      model_compare();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
